riscv_retire_monitor: RTL and testbench

Producer side of the core's observation interface. It consumes one retirement record per cycle from the single-cycle datapath and maintains the architectural observation outputs: `NUM_INST` (retired-instruction count), `OUTPUT_PORT` (last observable result) and `HALT` (end-of-program detection). It sits between the core's writeback/branch/store logic and the top-level `NUM_INST`/`OUTPUT_PORT`/`HALT` ports, which the test benches sample on each rising clock edge.

---
 rtl/riscv_retire_pkg.sv | 26 ++
 rtl/riscv_halt_detect.sv | 43 ++++
 rtl/riscv_retire_monitor.sv | 70 +++++++
 tb/tb_riscv_retire_monitor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/riscv_retire_pkg.sv
// Shared encodings for the retirement monitor: retire kinds, default halt
// words, halt-FSM states and the saturating count helper.
package riscv_retire_pkg;

   typedef enum logic [1:0] {
      KIND_RD    = 2'd0,
      KIND_BR    = 2'd1,
      KIND_ST    = 2'd2,
      KIND_OTHER = 2'd3
   } ret_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAW0   = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_e;

   localparam logic [31:0] HALT_INST0_DEF = 32'h00c0_0093;  // addi x1,x0,12
   localparam logic [31:0] HALT_INST1_DEF = 32'h0000_8067;  // jalr x0,0(x1)

   // The retired-instruction count sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-sequence detector: watches accepted retires for HALT_INST0 followed
// (bubbles allowed) by HALT_INST1, then latches HALT until reset.
module riscv_halt_detect
   import riscv_retire_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
   parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        accept,
   input  logic [31:0] RET_INST,
   output logic        HALT
);

   halt_state_e state_q, state_d;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (RET_INST == HALT_INST0) state_d = ST_SAW0;
            end
            ST_SAW0: begin
               // A repeated first word keeps the sequence armed.
               if (RET_INST == HALT_INST1)      state_d = ST_HALTED;
               else if (RET_INST != HALT_INST0) state_d = ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   assign HALT = (state_q == ST_HALTED);

endmodule

// File: rtl/riscv_retire_monitor.sv
// Observation-interface producer: counts retires, tracks the last observable
// result per retire kind, and reports end-of-program via the halt detector.
module riscv_retire_monitor
   import riscv_retire_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
   parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RET_VALID,
   input  logic [31:0] RET_INST,
   input  logic [1:0]  RET_KIND,
   input  logic [31:0] RET_WD,
   input  logic        RET_TAKEN,
   input  logic [31:0] RET_ADDR,
   output logic [31:0] NUM_INST,
   output logic [31:0] OUTPUT_PORT,
   output logic        HALT
);

   logic        accept;
   logic        halt;
   logic [31:0] num_q, num_d;
   logic [31:0] port_q, port_d;

   // Once halted, retires are dropped so count and port freeze.
   assign accept = RET_VALID && !halt;

   riscv_halt_detect #(
      .HALT_INST0 (HALT_INST0),
      .HALT_INST1 (HALT_INST1)
   ) u_halt_detect (
      .CLK      (CLK),
      .RST      (RST),
      .accept   (accept),
      .RET_INST (RET_INST),
      .HALT     (halt)
   );

   always_comb begin
      num_d  = num_q;
      port_d = port_q;
      if (accept) begin
         num_d = sat_inc(num_q);
         case (ret_kind_e'(RET_KIND))
            KIND_RD:    port_d = RET_WD;
            KIND_BR:    port_d = {31'b0, RET_TAKEN};
            KIND_ST:    port_d = RET_ADDR;
            KIND_OTHER: port_d = port_q;
            default:    port_d = port_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         num_q  <= 32'd0;
         port_q <= 32'd0;
      end else begin
         num_q  <= num_d;
         port_q <= port_d;
      end
   end

   assign NUM_INST    = num_q;
   assign OUTPUT_PORT = port_q;
   assign HALT        = halt;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Directed bench for riscv_retire_monitor: the stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_riscv_retire_monitor;

   localparam logic [31:0] H0  = 32'h00c0_0093;
   localparam logic [31:0] H1  = 32'h0000_8067;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        RET_VALID = 1'b0;
   logic [31:0] RET_INST = '0;
   logic [1:0]  RET_KIND = '0;
   logic [31:0] RET_WD = '0;
   logic        RET_TAKEN = 1'b0;
   logic [31:0] RET_ADDR = '0;
   logic [31:0] NUM_INST;
   logic [31:0] OUTPUT_PORT;
   logic        HALT;

   typedef struct {
      logic [31:0] num;
      logic [31:0] port;
      logic        halt;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   riscv_retire_monitor dut (
      .CLK         (CLK),
      .RST         (RST),
      .RET_VALID   (RET_VALID),
      .RET_INST    (RET_INST),
      .RET_KIND    (RET_KIND),
      .RET_WD      (RET_WD),
      .RET_TAKEN   (RET_TAKEN),
      .RET_ADDR    (RET_ADDR),
      .NUM_INST    (NUM_INST),
      .OUTPUT_PORT (OUTPUT_PORT),
      .HALT        (HALT)
   );

   always #5 CLK = ~CLK;

   // Monitor: outputs are registered, so the negedge sees the state after the
   // preceding posedge, which is what the head of the queue describes.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (NUM_INST !== e.num || OUTPUT_PORT !== e.port || HALT !== e.halt) begin
            miscompares++;
            $display("FAIL %s: got num=%h port=%h halt=%b, expected num=%h port=%h halt=%b",
                     e.name, NUM_INST, OUTPUT_PORT, HALT, e.num, e.port, e.halt);
         end
      end
   end

   // One clock of stimulus followed by the expected post-edge outputs.
   task automatic step(input string name, input logic rst, input logic vld,
                       input logic [31:0] inst, input logic [1:0] kind,
                       input logic [31:0] wd, input logic taken,
                       input logic [31:0] addr, input logic [31:0] e_num,
                       input logic [31:0] e_port, input logic e_halt);
      exp_t e;
      @(negedge CLK);
      #1;
      RST = rst; RET_VALID = vld; RET_INST = inst; RET_KIND = kind;
      RET_WD = wd; RET_TAKEN = taken; RET_ADDR = addr;
      @(posedge CLK);
      #1;
      e.num = e_num; e.port = e_port; e.halt = e_halt; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string name, input logic [31:0] e_num,
                       input logic [31:0] e_port, input logic e_halt);
      step(name, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd0, 32'hBAD0_BAD0, 1'b1,
           32'h1234_5678, e_num, e_port, e_halt);
   endtask

   task automatic reset1(input string name);
      step(name, 1'b1, 1'b0, '0, 2'd0, '0, 1'b0, '0, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      // Reset values, held through idle cycles
      reset1("rst_a");
      reset1("rst_b");
      for (int i = 0; i < 5; i++) idle("rst_idle", 32'd0, 32'd0, 1'b0);

      // Kind mux, with junk in the unselected fields
      step("k0_wd",    0, 1, NOP,          2'd0, 32'h0000_0eec, 1'b1, 32'hFFFF_0000, 32'd1, 32'h0eec, 0);
      step("k1_taken", 0, 1, 32'h0000_0063, 2'd1, 32'hDEAD_0000, 1'b1, 32'hAAAA_AAAA, 32'd2, 32'h0001, 0);
      step("k2_addr",  0, 1, 32'h0000_0023, 2'd2, 32'h5555_5555, 1'b1, 32'h0000_0ed8, 32'd3, 32'h0ed8, 0);
      step("k3_hold",  0, 1, 32'h0000_000f, 2'd3, 32'h7777_7777, 1'b1, 32'h8888_8888, 32'd4, 32'h0ed8, 0);
      step("k1_ntkn",  0, 1, 32'h0000_0063, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'd5, 32'h0000, 0);
      idle("bubble_hold", 32'd5, 32'd0, 0);

      // Halt across a bubble, then frozen
      reset1("rst_t3");
      step("t3_h0",   0, 1, H0, 2'd0, 32'd12, 0, 0, 32'd1, 32'd12, 0);
      idle("t3_bub",  32'd1, 32'd12, 0);
      step("t3_h1",   0, 1, H1, 2'd3, 32'd99, 0, 0, 32'd2, 32'd12, 1);
      step("t3_frz1", 0, 1, H0, 2'd0, 32'h55, 0, 0, 32'd2, 32'd12, 1);
      step("t3_frz2", 0, 1, NOP, 2'd0, 32'h55, 0, 0, 32'd2, 32'd12, 1);

      // Broken sequence, then a clean one
      reset1("rst_t4");
      step("t4_h0",   0, 1, H0,  2'd0, 32'd12, 0, 0, 32'd1, 32'd12, 0);
      step("t4_nop",  0, 1, NOP, 2'd0, 32'd0,  0, 0, 32'd2, 32'd0,  0);
      step("t4_h1",   0, 1, H1,  2'd3, 32'd7,  0, 0, 32'd3, 32'd0,  0);
      step("t4_h0b",  0, 1, H0,  2'd0, 32'd12, 0, 0, 32'd4, 32'd12, 0);
      step("t4_h1b",  0, 1, H1,  2'd3, 32'd7,  0, 0, 32'd5, 32'd12, 1);

      // Repeated first word
      reset1("rst_t5");
      step("t5_h0a",  0, 1, H0, 2'd0, 32'd12, 0, 0, 32'd1, 32'd12, 0);
      step("t5_h0b",  0, 1, H0, 2'd0, 32'd12, 0, 0, 32'd2, 32'd12, 0);
      step("t5_h1",   0, 1, H1, 2'd3, 32'd0,  0, 0, 32'd3, 32'd12, 1);

      // Reset mid-sequence and reset priority over a valid retire
      reset1("rst_t6");
      step("t6_h0",   0, 1, H0, 2'd0, 32'd12, 0, 0, 32'd1, 32'd12, 0);
      reset1("t6_rst_mid");
      step("t6_h1",   0, 1, H1, 2'd3, 32'd0,  0, 0, 32'd1, 32'd0,  0);
      step("t6_h0b",  0, 1, H0, 2'd0, 32'd12, 0, 0, 32'd2, 32'd12, 0);
      step("t6_rstv", 1, 1, H1, 2'd0, 32'h99, 0, 0, 32'd0, 32'd0,  0);
      step("t6_h1b",  0, 1, H1, 2'd3, 32'd0,  0, 0, 32'd1, 32'd0,  0);

      @(negedge CLK);
      #1;
      RST = 1'b0; RET_VALID = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
